// File: rtl/alu_pkg.sv
// Shared op-code encoding and execution-stage FSM states used by the ALU control
// decoder and the iterative execution stage.
package alu_pkg;

    localparam logic [3:0] OP_NOT = 4'b0000;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_MUL = 4'b0110;
    localparam logic [3:0] OP_DIV = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } alu_state_e;

endpackage

// File: rtl/iter_muldiv.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per step,
// WIDTH steps per operation. Sequencing is owned by the parent via start/step.
module iter_muldiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder
);

    logic             mode_q, mode_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   trial;
    logic             sub_ok;
    logic [WIDTH-1:0] diff;

    // quo_q starts as the dividend and fills with quotient bits from the right
    assign trial  = {rem_q, quo_q[WIDTH-1]};
    assign sub_ok = trial >= {1'b0, dvsr_q};
    assign diff   = trial[WIDTH-1:0] - dvsr_q;

    always_comb begin
        mode_d   = mode_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        cnt_d    = cnt_q;
        if (start) begin
            mode_d   = is_div;
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            rem_d    = '0;
            quo_d    = a;
            dvsr_d   = b;
            cnt_d    = CNT_W'(WIDTH);
        end else if (step && (cnt_q != '0)) begin
            if (mode_q) begin
                rem_d = sub_ok ? diff : trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], sub_ok};
            end else begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
            end
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
        end else begin
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            cnt_q    <= cnt_d;
        end
    end

    // High during the final iteration; the result is complete after this edge
    assign done      = step && (cnt_q == CNT_W'(1));
    assign result    = mode_q ? quo_q : acc_q;
    assign remainder = mode_q ? rem_q : '0;

endmodule

// File: rtl/iter_alu.sv
// Execution stage: single-cycle logic/add/sub, iterative mul/div, valid/ready
// handshake and registered result/flag outputs.
module iter_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             zero,
    output logic             div_by_zero,
    output logic             illegal_op,
    output logic             out_valid
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;
    logic             illegal_q, illegal_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             md_start, md_step, md_done;
    logic [WIDTH-1:0] md_result, md_remainder;
    logic [WIDTH-1:0] simple_val;

    logic             fin;
    logic [WIDTH-1:0] fin_res, fin_rem;
    logic             fin_dbz, fin_ill;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready && !flush;
    assign md_step  = ((state_q == MUL) || (state_q == DIV)) && !flush;

    always_comb begin
        unique case (control)
            OP_NOT:  simple_val = ~a;
            OP_AND:  simple_val = a & b;
            OP_OR:   simple_val = a | b;
            OP_XOR:  simple_val = a ^ b;
            OP_ADD:  simple_val = a + b;
            OP_SUB:  simple_val = a - b;
            default: simple_val = '0;
        endcase
    end

    iter_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (md_start),
        .step      (md_step),
        .is_div    (control == OP_DIV),
        .a         (a),
        .b         (b),
        .done      (md_done),
        .result    (md_result),
        .remainder (md_remainder)
    );

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        illegal_d   = illegal_q;
        out_valid_d = 1'b0;
        md_start    = 1'b0;
        fin         = 1'b0;
        fin_res     = '0;
        fin_rem     = '0;
        fin_dbz     = 1'b0;
        fin_ill     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (control[3]) begin
                        fin     = 1'b1;
                        fin_ill = 1'b1;
                    end else if (control == OP_MUL) begin
                        state_d  = MUL;
                        md_start = 1'b1;
                    end else if (control == OP_DIV) begin
                        if (b == '0) begin
                            fin     = 1'b1;
                            fin_res = '1;
                            fin_rem = a;
                            fin_dbz = 1'b1;
                        end else begin
                            state_d  = DIV;
                            md_start = 1'b1;
                        end
                    end else begin
                        fin     = 1'b1;
                        fin_res = simple_val;
                    end
                end
            end
            MUL, DIV: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (md_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!flush) begin
                    fin     = 1'b1;
                    fin_res = md_result;
                    fin_rem = md_remainder;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            result_d    = fin_res;
            remainder_d = fin_rem;
            zero_d      = (fin_res == '0);
            dbz_d       = fin_dbz;
            illegal_d   = fin_ill;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            remainder_q <= '0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result      = result_q;
    assign remainder   = remainder_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;
    assign illegal_op  = illegal_q;
    assign out_valid   = out_valid_q;

endmodule
